// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle control FSM and the datapath/memory.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       trap;
  logic [3:0] state;

  modport slave (
    input  opcode, funct3, funct7_5, Zero, mem_ready,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, state
  );
  modport master (
    output opcode, funct3, funct7_5, Zero, mem_ready,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I-subset control FSM with memory-ready stalls, optional
// per-request wait timeout, and a sticky trap state.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.slave    bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_LUI = 4'd11,
    S_TRAP = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R  = 7'b0110011, OP_I  = 7'b0010011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111;

  state_t cur, nxt;
  logic [TO_W-1:0] wait_cnt;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap_s;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_ctl;

  // Bit 30 only selects SUB for R-type; ADDI carries immediate bits there.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f75,
                                         input logic rtype);
    case (f3)
      3'b000:  return (rtype && f75) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return f75 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    trap_s     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    alu_ctl    = ALU_ADD;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BR:        nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          OP_LUI:       nxt = S_LUI;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (bus.opcode == OP_SW) ? 3'b001 : 3'b000;
        nxt       = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.mem_ready) nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctl   = alu_dec(bus.funct3, bus.funct7_5, 1'b1);
        nxt       = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctl   = alu_dec(bus.funct3, bus.funct7_5, 1'b0);
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctl   = ALU_SUB;
        pc_write  = ((bus.funct3 == 3'b000) &&  bus.Zero) ||
                    ((bus.funct3 == 3'b001) && !bus.Zero);
        nxt       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 3'b011;
        pc_write  = 1'b1;
        nxt       = S_ALUWB;
      end
      S_LUI: begin
        imm_src    = 3'b100;
        result_src = 2'b11;
        reg_write  = 1'b1;
        nxt        = S_FETCH;
      end
      default: begin
        trap_s = 1'b1;
        nxt    = S_TRAP;
      end
    endcase
    // A late mem_ready on the expiry cycle still completes the request.
    if (MEM_TIMEOUT > 0 && mem_req && !bus.mem_ready &&
        wait_cnt == TO_W'(MEM_TIMEOUT - 1))
      nxt = S_TRAP;
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_to
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         wait_cnt <= '0;
        else if (nxt != cur || bus.mem_ready || !mem_req) wait_cnt <= '0;
        else                                             wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin : g_no_to
      assign wait_cnt = '0;
    end
  endgenerate

  // Reset forces every output low combinationally, not just at the next edge.
  assign bus.MemReq     = !rst && mem_req;
  assign bus.MemWrite   = !rst && mem_write;
  assign bus.AdrSrc     = !rst && adr_src;
  assign bus.IRWrite    = !rst && ir_write;
  assign bus.PCWrite    = !rst && pc_write;
  assign bus.RegWrite   = !rst && reg_write;
  assign bus.trap       = !rst && trap_s;
  assign bus.ResultSrc  = rst ? 2'b00 : result_src;
  assign bus.ALUSrcA    = rst ? 2'b00 : alu_src_a;
  assign bus.ALUSrcB    = rst ? 2'b00 : alu_src_b;
  assign bus.ImmSrc     = rst ? 3'b000 : imm_src;
  assign bus.ALUControl = rst ? 4'b0000 : alu_ctl;
  assign bus.state      = rst ? 4'd0 : cur;
endmodule
